// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch block.
package pc_fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_TRAP = 2'd3
    } fetch_state_e;

    // Canonical RISC-V NOP (addi x0, x0, 0) shown on inst before any fetch.
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          STALL_CNT_W      = 16;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc4(input logic [31:0] pc_v);
        return pc_v + 32'd4;
    endfunction

endpackage

// File: rtl/pc_target.sv
// Next-PC target selection and alignment check (purely combinational).
module pc_target
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        jalr,
    output logic [31:0] target,
    output logic        target_misaligned
);

    // Pick redirect target (bit 0 cleared for JALR) or fall through to pc+4.
    always_comb begin
        target = pc_inc4(pc);
        if (redirect) begin
            if (jalr) begin
                target = {next_pc[31:1], 1'b0};
            end else begin
                target = next_pc;
            end
        end else begin
            target = pc_inc4(pc);
        end
        // Bit 0 is even by construction; only a set bit 1 breaks word alignment.
        target_misaligned = target[1];
    end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Holds each fetched instruction until decode accepts it, then commits the
// next PC; a misaligned target parks the block in TRAP until reset.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            next_pc,
    input  logic                   jalr,
    input  logic                   redirect,
    input  logic                   advance,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   inst_valid,
    output logic [31:0]            inst,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   misaligned,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e           state_r;
    fetch_state_e           state_nx_s;
    logic [31:0]            pc_r;
    logic [31:0]            inst_r;
    logic                   inst_valid_r;
    logic                   imem_req_r;
    logic                   misaligned_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic [31:0]            target_s;
    logic                   target_mis_s;
    logic                   take_ack_s;
    logic                   stall_inc_s;
    logic                   commit_s;
    logic                   trap_s;

    pc_target u_pc_target (
        .pc                (pc_r),
        .next_pc           (next_pc),
        .redirect          (redirect),
        .jalr              (jalr),
        .target            (target_s),
        .target_misaligned (target_mis_s)
    );

    // Next-state and per-cycle update strobes for the fetch sequencer.
    always_comb begin
        state_nx_s  = state_r;
        take_ack_s  = 1'b0;
        stall_inc_s = 1'b0;
        commit_s    = 1'b0;
        trap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    take_ack_s = 1'b1;
                    state_nx_s = ST_HOLD;
                end else begin
                    // Counter saturates rather than wrapping.
                    stall_inc_s = (stall_cnt_r != STALL_MAX);
                    state_nx_s  = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    commit_s = 1'b1;
                    if (target_mis_s) begin
                        trap_s     = 1'b1;
                        state_nx_s = ST_TRAP;
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_TRAP: begin
                state_nx_s = ST_TRAP;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, PC, held instruction, flags and stall counter; outputs registered from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            inst_r       <= INST_NOP;
            inst_valid_r <= 1'b0;
            imem_req_r   <= 1'b0;
            misaligned_r <= 1'b0;
            stall_cnt_r  <= {STALL_CNT_W{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            imem_req_r   <= (state_nx_s == ST_REQ);
            inst_valid_r <= (state_nx_s == ST_HOLD);
            if (take_ack_s) begin
                inst_r <= imem_rdata;
            end
            if (stall_inc_s) begin
                stall_cnt_r <= stall_cnt_r + STALL_ONE;
            end
            if (commit_s) begin
                pc_r <= target_s;
            end
            if (trap_s) begin
                misaligned_r <= 1'b1;
            end
        end
    end

    assign imem_req     = imem_req_r;
    assign imem_addr    = pc_r;
    assign inst_valid   = inst_valid_r;
    assign inst         = inst_r;
    assign pc           = pc_r;
    assign pc_plus4     = pc_inc4(pc_r);
    assign misaligned   = misaligned_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: two instances (reset PC 0 and 0xFFFF_FFFC)
// driven in lockstep, compared every cycle against a behavioural model.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic        jalr = 1'b0;
    logic        redirect = 1'b0;
    logic        advance = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        d0_req, d1_req, d0_iv, d1_iv, d0_mis, d1_mis;
    logic [31:0] d0_addr, d1_addr, d0_inst, d1_inst, d0_pc, d1_pc, d0_p4, d1_p4;
    logic [15:0] d0_st, d1_st;

    int checks = 0;
    int errors = 0;

    // Behavioural model, one slot per instance.
    logic [31:0] m_rst_pc [2];
    logic [31:0] m_pc     [2];
    logic [31:0] m_inst   [2];
    bit          m_fetching [2];
    bit          m_holding  [2];
    bit          m_halted   [2];
    bit          m_mis      [2];
    int unsigned m_stall    [2];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] held_word;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .jalr(jalr), .redirect(redirect),
        .advance(advance), .imem_req(d0_req), .imem_addr(d0_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(d0_iv), .inst(d0_inst), .pc(d0_pc),
        .pc_plus4(d0_p4), .misaligned(d0_mis), .stall_cycles(d0_st)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .jalr(jalr), .redirect(redirect),
        .advance(advance), .imem_req(d1_req), .imem_addr(d1_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(d1_iv), .inst(d1_inst), .pc(d1_pc),
        .pc_plus4(d1_p4), .misaligned(d1_mis), .stall_cycles(d1_st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step(input int i);
        logic [31:0] t;
        if (!rst_n) begin
            m_pc[i] = m_rst_pc[i];
            m_inst[i] = 32'h0000_0013;
            m_fetching[i] = 0; m_holding[i] = 0; m_halted[i] = 0;
            m_mis[i] = 0; m_stall[i] = 0;
        end else if (m_halted[i]) begin
            // parked until reset
        end else if (m_holding[i]) begin
            if (advance) begin
                if (redirect) t = jalr ? (next_pc & 32'hFFFF_FFFE) : next_pc;
                else          t = m_pc[i] + 32'd4;
                m_pc[i] = t;
                m_holding[i] = 0;
                if (((t / 2) % 2) == 1) begin
                    m_halted[i] = 1; m_mis[i] = 1;
                end else begin
                    m_fetching[i] = 1;
                end
            end
        end else if (m_fetching[i]) begin
            if (imem_ack) begin
                m_inst[i] = imem_rdata; m_fetching[i] = 0; m_holding[i] = 1;
            end else if (m_stall[i] < 65535) begin
                m_stall[i] = m_stall[i] + 1;
            end
        end else begin
            m_fetching[i] = 1;
        end
    endtask

    task automatic check_dut(input int i, input logic req, input logic [31:0] addr,
                             input logic iv, input logic [31:0] ins, input logic [31:0] pcv,
                             input logic [31:0] p4, input logic mis, input logic [15:0] st);
        string p;
        p = $sformatf("d%0d_", i);
        chk({p, "imem_req"},   {31'h0, req},  {31'h0, m_fetching[i]});
        chk({p, "imem_addr"},  addr,          m_pc[i]);
        chk({p, "inst_valid"}, {31'h0, iv},   {31'h0, m_holding[i]});
        chk({p, "inst"},       ins,           m_inst[i]);
        chk({p, "pc"},         pcv,           m_pc[i]);
        chk({p, "pc_plus4"},   p4,            m_pc[i] + 32'd4);
        chk({p, "misaligned"}, {31'h0, mis},  {31'h0, m_mis[i]});
        chk({p, "stall"},      {16'h0, st},   m_stall[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0, d0_req, d0_addr, d0_iv, d0_inst, d0_pc, d0_p4, d0_mis, d0_st);
        check_dut(1, d1_req, d1_addr, d1_iv, d1_inst, d1_pc, d1_p4, d1_mis, d1_st);
    endtask

    initial begin
        m_rst_pc[0] = 32'h0000_0000;
        m_rst_pc[1] = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0; m_inst[i] = 32'h0; m_fetching[i] = 0; m_holding[i] = 0;
            m_halted[i] = 0; m_mis[i] = 0; m_stall[i] = 0;
        end

        // Reset state.
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_pc0", d0_pc, 32'h0000_0000);
        chk("rst_pc1", d1_pc, 32'hFFFF_FFFC);
        chk("rst_inst", d0_inst, 32'h0000_0013);

        // Zero-wait memory with advance held high.
        rst_n = 1'b1; advance = 1'b1; imem_ack = 1'b1;
        for (int n = 0; n < 6; n++) begin
            imem_rdata = $urandom;
            tick();
            if (d0_req) q0.push_back(d0_addr);
            if (d1_req) q1.push_back(d1_addr);
        end
        chk("seq_len0", q0.size(), 32'd3);
        chk("seq_len1", q1.size(), 32'd3);
        if (q0.size() == 3 && q1.size() == 3) begin
            chk("seq0_a0", q0[0], 32'h0); chk("seq0_a1", q0[1], 32'h4); chk("seq0_a2", q0[2], 32'h8);
            chk("seq1_a0", q1[0], 32'hFFFF_FFFC); chk("seq1_a1", q1[1], 32'h0); chk("seq1_a2", q1[2], 32'h4);
        end
        chk("seq_stall", {16'h0, d0_st}, 32'h0);

        // Run up to HOLD at pc 0x10, then a JALR redirect to 0x105.
        for (int n = 0; n < 40 && !(m_holding[0] && m_pc[0] == 32'h10); n++) begin
            imem_rdata = $urandom;
            tick();
        end
        chk("reach_hold_10", {d0_iv, d0_pc[30:0]}, {1'b1, 31'h10});
        redirect = 1'b1; jalr = 1'b1; next_pc = 32'h0000_0105;
        tick();
        chk("jalr_addr0", d0_addr, 32'h0000_0104);
        chk("jalr_addr1", d1_addr, 32'h0000_0104);
        chk("jalr_mis", {31'h0, d0_mis}, 32'h0);

        // Memory withholds ack for three cycles.
        redirect = 1'b0; jalr = 1'b0; advance = 1'b0; imem_ack = 1'b0;
        for (int n = 0; n < 3; n++) begin
            imem_rdata = $urandom;
            tick();
            chk("wait_req", {31'h0, d0_req}, 32'h1);
            chk("wait_addr", d0_addr, 32'h0000_0104);
        end
        chk("wait_stall", {16'h0, d0_st}, 32'h3);
        held_word = $urandom;
        imem_ack = 1'b1; imem_rdata = held_word;
        tick();
        chk("ack_inst", d0_inst, held_word);
        // Stray ack while holding must not overwrite inst.
        imem_rdata = ~held_word;
        tick();
        chk("stray_inst", d0_inst, held_word);
        chk("stray_valid", {31'h0, d0_iv}, 32'h1);
        imem_ack = 1'b0;

        // Misaligned branch target traps.
        advance = 1'b1; redirect = 1'b1; jalr = 1'b0; next_pc = 32'h0000_0102;
        tick();
        chk("trap_pc", d0_pc, 32'h0000_0102);
        chk("trap_mis", {31'h0, d0_mis}, 32'h1);
        for (int n = 0; n < 5; n++) begin
            advance = 1'($urandom); imem_ack = 1'($urandom); next_pc = $urandom & 32'hFFFF_FFFC;
            tick();
            chk("trap_noreq", {31'h0, d0_req | d1_req}, 32'h0);
        end
        rst_n = 1'b0;
        tick();
        chk("trap_rst_pc0", d0_pc, 32'h0000_0000);
        chk("trap_rst_pc1", d1_pc, 32'hFFFF_FFFC);
        chk("trap_rst_mis", {31'h0, d0_mis}, 32'h0);

        // Reset while a request is pending; a late ack must be ignored.
        rst_n = 1'b1; advance = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        rst_n = 1'b1; imem_rdata = $urandom;
        tick();
        chk("late_ack_inst", d0_inst, 32'h0000_0013);
        chk("late_ack_valid", {31'h0, d0_iv}, 32'h0);
        imem_ack = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            imem_ack   = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            advance    = 1'($urandom);
            redirect   = ($urandom_range(0, 3) == 0);
            jalr       = 1'($urandom);
            next_pc    = $urandom;
            if ($urandom_range(0, 7) != 0) next_pc = next_pc & 32'hFFFF_FFFD;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
